path_delay_meter: RTL and testbench
===================================

# path_delay_meter

Launch-and-capture controller that sits directly upstream and downstream of one inverter delay chain under test. It drives the chain's `pathInput`, samples its `pathResult` through a two-flop synchronizer, and counts clock cycles from each launched transition until the transition arrives. It repeats this for a programmable number of alternating-polarity launches and reports sum, minimum and maximum delay. Trojan detection logic compares these figures against golden values.

## Interface
Parameters:
- `CNT_W`, 16: width of the per-launch delay counter and of `delayMin`/`delayMax`.
- `TIMEOUT`, 1000: cycle limit for one launch and for one settle phase. Must satisfy 3 ≤ TIMEOUT < 2^CNT_W.
- `INVERTING`, 0: 1 if the chain has an odd number of inverting stages. Expected result level is `pathInput ^ INVERTING`.

Ports:
- `clk`, input, 1: single clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request a measurement. Sampled only in IDLE.
- `numRuns`, input, 8: number of launches. Sampled when `start` is accepted.
- `pathInput`, output, 1: drives the chain input. Registered.
- `pathResult`, input, 1: chain output. Asynchronous to `clk`.
- `busy`, output, 1: high from the cycle after `start` is accepted until DONE is exited.
- `done`, output, 1: one-cycle pulse at the end of a measurement.
- `timeoutErr`, output, 1: set when a launch or settle exceeds TIMEOUT. Holds until the next accepted start.
- `runCount`, output, 8: number of completed launches.
- `delaySum`, output, CNT_W+8: accumulated delay of completed launches.
- `delayMin`, output, CNT_W: smallest delay of completed launches.
- `delayMax`, output, CNT_W: largest delay of completed launches.

## Operation
- Synchronizer: `s1 <= pathResult`, `s2 <= s1`. All decisions use `s2` only. `match = (s2 == pathInput ^ INVERTING)`.
- FSM states and transitions:
  - IDLE:
    - `start=1` and `numRuns≠0`: clear `runCount` and `delaySum` to 0, `delayMin` to all ones, `delayMax` to 0 and `timeoutErr` to 0. Go to SETTLE.
    - `start=1` and `numRuns=0`: clear the results the same way, never toggle `pathInput`, go to DONE.
  - SETTLE: wait for `match`, which confirms the chain is static at the current level, then go to LAUNCH. If `match` is not seen within TIMEOUT cycles, set `timeoutErr` and go to DONE.
  - LAUNCH: one cycle. Toggle `pathInput` at the exiting edge E0, clear the counter, go to WAIT.
  - WAIT: the counter increments on every edge. D is the index of the first edge after E0 at which `s2` captures the expected level (zero-delay chain gives D=2). On `match`:
    - `delaySum += D`, `runCount += 1`.
    - Update `delayMin` and `delayMax` with unsigned compares.
    - If the new `runCount == numRuns`, go to DONE; otherwise go to SETTLE.
    - If the counter reaches TIMEOUT without `match`: set `timeoutErr`, do not record the run, go to DONE.
  - DONE: `done=1` for exactly one cycle, `busy` drops, go to IDLE.
- Polarity alternates every launch. The first launch after reset is rising. `pathInput` is not reset between measurements; it keeps alternating.
- `start` while busy is ignored and not queued.
- Results hold stable from DONE until the next accepted start.
- `delaySum` cannot overflow, because 255 × (2^CNT_W − 1) fits in CNT_W+8 bits.

## Timing
- Reset values: `pathInput=0`, `busy=0`, `done=0`, `timeoutErr=0`, `runCount=0`, `delaySum=0`, `delayMin` all ones, `delayMax=0`, synchronizer flops 0, FSM in IDLE.
- Reset asserted mid-measurement: everything returns to reset values immediately, no `done` pulse. After release, the block waits for a fresh `start`.
- From `start` accepted (edge S) to the first launch: SETTLE occupies edges S+1.., LAUNCH follows the first matching cycle.
- Recording happens on the edge after the capture edge (D+1 after E0). The next SETTLE follows immediately.
- `done` rises one cycle after the final recording, or after the timeout edge. `busy` is low in the cycle `done` is high.
- `numRuns=0`: `done` is high 2 cycles after the accepting edge, and `pathInput` is unchanged.

## Test plan
- Zero-delay loopback (`pathResult=pathInput`), INVERTING=0, `numRuns=4` → `delaySum=8`, `delayMin=delayMax=2`, `runCount=4`, `timeoutErr=0`, `pathInput` toggled 4 times and ending at its initial level.
- Bench inserts 3 `clk` registers in the loopback, `numRuns=10` → every D=5, `delaySum=50`, `min=max=5`.
- Bench delay alternates 1 and 6 registers per launch, `numRuns=6` → `delayMin=3`, `delayMax=8`, `delaySum=33`.
- `pathResult` tied 0, INVERTING=0, TIMEOUT=20 → first launch goes rising, `timeoutErr=1`, `runCount=0`, one `done` pulse.
- `numRuns=0` → `done` pulse 2 cycles after start, no `pathInput` toggle. Then `start` asserted while busy during a 4-run measurement → ignored, only one `done` pulse.
- Assert `rst` in WAIT of run 2 → all outputs return to reset values asynchronously, no `done`. A new `start` then completes normally.

Source files
------------

// File: rtl/path_delay_meter.sv
// Launch-and-capture delay meter for one delay chain: toggles the chain input,
// times arrival through a 2-flop synchronizer, and accumulates sum/min/max.
module path_delay_meter #(
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 1000,
    parameter int INVERTING = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         numRuns,
    output logic               pathInput,
    input  logic               pathResult,
    output logic               busy,
    output logic               done,
    output logic               timeoutErr,
    output logic [7:0]         runCount,
    output logic [CNT_W+7:0]   delaySum,
    output logic [CNT_W-1:0]   delayMin,
    output logic [CNT_W-1:0]   delayMax
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic             INV          = (INVERTING != 0);
    localparam logic [CNT_W-1:0] WAIT_LIMIT   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] SETTLE_LIMIT = CNT_W'(TIMEOUT - 1);

    state_t           state, state_next;
    logic             s1, s2;
    logic             match;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       runs_target;
    logic [7:0]       run_next;
    logic             last_run;

    // Control strobes produced by the output decoder
    logic accept, cnt_clr, cnt_inc, do_toggle, do_record, set_timeout;

    assign match    = (s2 == (pathInput ^ INV));
    assign run_next = runCount + 8'd1;
    assign last_run = (run_next == runs_target);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:
                if (start) state_next = (numRuns != 8'd0) ? ST_SETTLE : ST_DONE;
            ST_SETTLE:
                if (match)                     state_next = ST_LAUNCH;
                else if (cnt == SETTLE_LIMIT)  state_next = ST_DONE;
            ST_LAUNCH:
                state_next = ST_WAIT;
            ST_WAIT:
                if (match)                     state_next = last_run ? ST_DONE : ST_SETTLE;
                else if (cnt == WAIT_LIMIT)    state_next = ST_DONE;
            ST_DONE:
                state_next = ST_IDLE;
            default:
                state_next = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy        = 1'b0;
        accept      = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        do_toggle   = 1'b0;
        do_record   = 1'b0;
        set_timeout = 1'b0;
        unique case (state)
            ST_IDLE: begin
                accept  = start;
                cnt_clr = 1'b1;
            end
            ST_SETTLE: begin
                busy        = 1'b1;
                cnt_inc     = 1'b1;
                set_timeout = !match && (cnt == SETTLE_LIMIT);
            end
            ST_LAUNCH: begin
                busy      = 1'b1;
                do_toggle = 1'b1;
                cnt_clr   = 1'b1;
            end
            ST_WAIT: begin
                busy        = 1'b1;
                cnt_inc     = 1'b1;
                cnt_clr     = match;
                do_record   = match;
                set_timeout = !match && (cnt == WAIT_LIMIT);
            end
            ST_DONE: begin
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath. done is registered off the DONE state so it lands in the
    // cycle after DONE, when busy is already low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            pathInput   <= 1'b0;
            done        <= 1'b0;
            cnt         <= '0;
            runs_target <= 8'd0;
            runCount    <= 8'd0;
            delaySum    <= '0;
            delayMin    <= '1;
            delayMax    <= '0;
            timeoutErr  <= 1'b0;
        end else begin
            // NOTE: non-blocking here so s2 takes the old s1, giving two real stages.
            s1   <= pathResult;
            s2   <= s1;
            done <= (state == ST_DONE);

            if (accept) begin
                runs_target <= numRuns;
                runCount    <= 8'd0;
                delaySum    <= '0;
                delayMin    <= '1;
                delayMax    <= '0;
                timeoutErr  <= 1'b0;
            end

            if (do_toggle) pathInput <= ~pathInput;

            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;

            if (do_record) begin
                delaySum <= delaySum + (CNT_W+8)'(cnt);
                runCount <= run_next;
                if (cnt < delayMin) delayMin <= cnt;
                if (cnt > delayMax) delayMax <= cnt;
            end

            if (set_timeout) timeoutErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_path_delay_meter.sv
// Scoreboard bench for path_delay_meter: a bench-side register chain closes
// the loop, expected results are queued at start and checked on each done.
module tb_path_delay_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 20;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         numRuns;
    logic               pathInput;
    logic               pathResult;
    logic               busy;
    logic               done;
    logic               timeoutErr;
    logic [7:0]         runCount;
    logic [CNT_W+7:0]   delaySum;
    logic [CNT_W-1:0]   delayMin;
    logic [CNT_W-1:0]   delayMax;

    path_delay_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .INVERTING(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .numRuns    (numRuns),
        .pathInput  (pathInput),
        .pathResult (pathResult),
        .busy       (busy),
        .done       (done),
        .timeoutErr (timeoutErr),
        .runCount   (runCount),
        .delaySum   (delaySum),
        .delayMin   (delayMin),
        .delayMax   (delayMax)
    );

    always #5 clk = ~clk;

    int checks     = 0;
    int failures   = 0;
    int done_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Chain model: k register stages of delay, or tied low
    logic [7:0] sr = 8'd0;
    int         k_fixed = 0;
    int         k_eff;
    bit         alt = 1'b0;
    bit         tie0 = 1'b0;
    int         toggles = 0;
    int         toggle_base = 0;
    int         idx;

    always @(posedge clk) sr <= {sr[6:0], pathInput};
    always @(pathInput) toggles++;

    // Alternating mode: launch 1,3,5 use 1 stage, launch 2,4,6 use 6 stages
    always_comb begin
        idx   = toggles - toggle_base;
        k_eff = k_fixed;
        if (alt) k_eff = (idx != 0 && (idx % 2) == 0) ? 6 : 1;
    end

    assign pathResult = tie0 ? 1'b0 : ((k_eff == 0) ? pathInput : sr[k_eff-1]);

    // Scoreboard
    typedef struct {
        logic [7:0]        runs;
        logic [CNT_W+7:0]  sum;
        logic [CNT_W-1:0]  mn;
        logic [CNT_W-1:0]  mx;
        logic              to;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            done_count++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0 t=%0t", $time);
            end else begin
                e = sb.pop_front();
                check("runCount",   32'(runCount),   32'(e.runs));
                check("delaySum",   32'(delaySum),   32'(e.sum));
                check("delayMin",   32'(delayMin),   32'(e.mn));
                check("delayMax",   32'(delayMax),   32'(e.mx));
                check("timeoutErr", 32'(timeoutErr), 32'(e.to));
            end
        end
    end

    function automatic exp_t mk(input int runs, input int sum, input int mn, input int mx, input bit to);
        exp_t r;
        r.runs = 8'(runs);
        r.sum  = (CNT_W+8)'(sum);
        r.mn   = CNT_W'(mn);
        r.mx   = CNT_W'(mx);
        r.to   = to;
        return r;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_pathInput"},  32'(pathInput),  32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_timeoutErr"}, 32'(timeoutErr), 32'd0);
        check({tag, "_runCount"},   32'(runCount),   32'd0);
        check({tag, "_delaySum"},   32'(delaySum),   32'd0);
        check({tag, "_delayMin"},   32'(delayMin),   32'hFFFF);
        check({tag, "_delayMax"},   32'(delayMax),   32'd0);
    endtask

    // Pulse start for one rising edge; returns just after the accepting edge
    task automatic do_start(input logic [7:0] n);
        @(negedge clk);
        numRuns = n;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic p0;
        int   t0;
        int   d0;

        rst     = 1'b1;
        start   = 1'b0;
        numRuns = 8'd0;
        #1 check_reset("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Zero-delay loopback, 4 runs: D=2 each
        p0 = pathInput;
        t0 = toggles;
        sb.push_back(mk(4, 8, 2, 2, 0));
        do_start(8'd4);
        wait_done("done_zero_delay", 200);
        check("zero_toggles", 32'(toggles - t0), 32'd4);
        check("zero_pathInput_final", 32'(pathInput), 32'(p0));

        // Three bench registers, 10 runs: D=5 each
        k_fixed = 3;
        repeat (10) @(negedge clk);
        sb.push_back(mk(10, 50, 5, 5, 0));
        do_start(8'd10);
        wait_done("done_three_regs", 400);

        // Alternating 1 and 6 registers, 6 runs: D=3,8,3,8,3,8
        repeat (10) @(negedge clk);
        toggle_base = toggles;
        alt = 1'b1;
        repeat (10) @(negedge clk);
        sb.push_back(mk(6, 33, 3, 8, 0));
        do_start(8'd6);
        wait_done("done_alternating", 400);
        alt = 1'b0;
        k_fixed = 0;

        // Result tied low: first launch rises and never arrives
        repeat (10) @(negedge clk);
        check("pre_timeout_pathInput", 32'(pathInput), 32'd0);
        tie0 = 1'b1;
        repeat (4) @(negedge clk);
        d0 = done_count;
        sb.push_back(mk(0, 0, 16'hFFFF, 0, 1));
        do_start(8'd3);
        wait_done("done_timeout", 200);
        check("timeout_pathInput_rising", 32'(pathInput), 32'd1);
        repeat (40) @(negedge clk);
        check("timeout_single_done", 32'(done_count - d0), 32'd1);
        tie0 = 1'b0;
        repeat (10) @(negedge clk);

        // numRuns=0: done in the second cycle after accept, no toggle, error cleared
        p0 = pathInput;
        t0 = toggles;
        sb.push_back(mk(0, 0, 16'hFFFF, 0, 0));
        do_start(8'd0);
        @(negedge clk);
        check("n0_done_cycle1", 32'(done), 32'd0);
        check("n0_busy_cycle1", 32'(busy), 32'd1);
        @(negedge clk);
        check("n0_done_cycle2", 32'(done), 32'd1);
        check("n0_busy_cycle2", 32'(busy), 32'd0);
        check("n0_pathInput", 32'(pathInput), 32'(p0));
        check("n0_toggles", 32'(toggles - t0), 32'd0);
        repeat (5) @(negedge clk);

        // start held while busy is ignored
        d0 = done_count;
        sb.push_back(mk(4, 8, 2, 2, 0));
        do_start(8'd4);
        repeat (2) @(negedge clk);
        numRuns = 8'd7;
        start   = 1'b1;
        repeat (6) @(negedge clk);
        start   = 1'b0;
        wait_done("done_busy_start", 200);
        repeat (40) @(negedge clk);
        check("busy_start_single_done", 32'(done_count - d0), 32'd1);
        check("busy_start_idle", 32'(busy), 32'd0);

        // Reset during WAIT of run 2
        k_fixed = 3;
        repeat (10) @(negedge clk);
        d0 = done_count;
        t0 = toggles;
        do_start(8'd4);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (toggles - t0 >= 2) break;
        end
        check("reached_run2", 32'(toggles - t0), 32'd2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset("midrun_reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        k_fixed = 0;
        repeat (10) @(negedge clk);
        check("midrun_no_done", 32'(done_count - d0), 32'd0);
        check("post_reset_pathInput", 32'(pathInput), 32'd0);
        sb.push_back(mk(2, 4, 2, 2, 0));
        do_start(8'd2);
        wait_done("done_after_reset", 200);
        repeat (5) @(negedge clk);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
